// File: rtl/mips_bp_pkg.sv
// Shared types and helpers for the branch predictor: FSM states, table entry width
// and saturating-counter constants.
package mips_bp_pkg;

    typedef enum logic {INIT, RUN} bp_state_e;

    function automatic int entry_width(input int tag_w, input int ctr_w, input int addr_w);
        return 1 + tag_w + ctr_w + addr_w;
    endfunction

    // Weakly-not-taken: the counter value just below the taken threshold.
    function automatic int wnt_value(input int ctr_w);
        return (1 << (ctr_w - 1)) - 1;
    endfunction

    function automatic int ctr_max(input int ctr_w);
        return (1 << ctr_w) - 1;
    endfunction

endpackage

// File: rtl/bp_sat_counter.sv
// Combinational saturating up/down counter step used to train a BHT entry.
module bp_sat_counter
    import mips_bp_pkg::*;
#(
    parameter int CTR_W = 2
) (
    input  logic [CTR_W-1:0] value,
    input  logic             inc,
    output logic [CTR_W-1:0] result
);

    localparam logic [CTR_W-1:0] CTR_MAX = CTR_W'(ctr_max(CTR_W));

    always_comb begin
        result = value;
        if (inc) begin
            if (value != CTR_MAX) result = value + 1'b1;
        end else begin
            if (value != '0) result = value - 1'b1;
        end
    end

endmodule

// File: rtl/branch_predictor.sv
// Direct-mapped BHT with tagged BTB, one-cycle registered lookup and post-reset init sweep.
// Optional gshare indexing is enabled by defining BP_GSHARE_EN.
module branch_predictor
    import mips_bp_pkg::*;
#(
    parameter int ADDR_W = 32,
    parameter int IDX_W  = 10,
    parameter int TAG_W  = 8,
    parameter int CTR_W  = 2,
    parameter int HIST_W = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              stall,
    input  logic              lookup_en,
    input  logic [ADDR_W-1:0] lookup_pc,
    output logic              pred_hit,
    output logic              pred_taken,
    output logic [ADDR_W-1:0] pred_target,
    output logic [CTR_W-1:0]  pred_token,
    output logic [IDX_W-1:0]  pred_index,
    input  logic              update_en,
    input  logic [IDX_W-1:0]  update_index,
    input  logic [ADDR_W-1:0] update_pc,
    input  logic [CTR_W-1:0]  update_token,
    input  logic              update_taken,
    input  logic [ADDR_W-1:0] update_target,
    output logic              busy
);

    localparam int DEPTH   = 2 ** IDX_W;
    localparam int ENTRY_W = entry_width(TAG_W, CTR_W, ADDR_W);
    localparam logic [CTR_W-1:0] WNT      = CTR_W'(wnt_value(CTR_W));
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DEPTH - 1);

    typedef struct packed {
        logic              valid;
        logic [TAG_W-1:0]  tag;
        logic [CTR_W-1:0]  ctr;
        logic [ADDR_W-1:0] tgt;
    } entry_t;

    logic [ENTRY_W-1:0] table_mem [DEPTH];

    bp_state_e         state, state_next;
    logic [IDX_W-1:0]  init_cnt;
    logic [IDX_W-1:0]  lookup_idx;
    logic [TAG_W-1:0]  lookup_tag;
    logic              lookup_hit;
    logic              run_update;
    logic              wr_en;
    logic [IDX_W-1:0]  wr_idx;
    entry_t            wr_entry;
    entry_t            rd_entry;
    logic [CTR_W-1:0]  upd_ctr;
    logic              unused_pc;

    assign lookup_tag = lookup_pc[IDX_W+TAG_W+1:IDX_W+2];
    assign run_update = (state == RUN) && update_en;
    assign busy       = (state == INIT);
    assign unused_pc  = ^{lookup_pc, update_pc};

`ifdef BP_GSHARE_EN
    logic [HIST_W-1:0] ghr;

    // History only advances on resolved branches, so it never needs repair.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ghr <= '0;
        end else if (state == INIT) begin
            ghr <= '0;
        end else if (run_update) begin
            ghr <= {ghr[HIST_W-2:0], update_taken};
        end
    end

    assign lookup_idx = lookup_pc[IDX_W+1:2] ^ IDX_W'(ghr);
`else
    logic [31:0] unused_hist;
    assign unused_hist = HIST_W;
    assign lookup_idx  = lookup_pc[IDX_W+1:2];
`endif

    bp_sat_counter #(.CTR_W(CTR_W)) u_sat_counter (
        .value  (update_token),
        .inc    (update_taken),
        .result (upd_ctr)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= INIT;
        else     state <= state_next;
    end

    always_comb begin
        state_next = state;
        unique case (state)
            INIT:    if (init_cnt == LAST_IDX) state_next = RUN;
            RUN:     state_next = RUN;
            default: state_next = INIT;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            init_cnt <= '0;
        end else if (state == INIT && init_cnt != LAST_IDX) begin
            init_cnt <= init_cnt + 1'b1;
        end
    end

    // Single write port shared by the init sweep and MEM-stage training.
    always_comb begin
        wr_en    = 1'b0;
        wr_idx   = init_cnt;
        wr_entry = '{valid: 1'b0, tag: '0, ctr: WNT, tgt: '0};
        if (state == INIT) begin
            wr_en = 1'b1;
        end else if (run_update) begin
            wr_en    = 1'b1;
            wr_idx   = update_index;
            wr_entry = '{valid: 1'b1,
                         tag:   update_pc[IDX_W+TAG_W+1:IDX_W+2],
                         ctr:   upd_ctr,
                         tgt:   update_target};
        end
    end

    always_ff @(posedge clk) begin
        if (wr_en) table_mem[wr_idx] <= wr_entry;
    end

    // Write-first bypass so a same-cycle update is visible to the lookup.
    always_comb begin
        rd_entry = table_mem[lookup_idx];
        if (wr_en && wr_idx == lookup_idx) rd_entry = wr_entry;
    end

    assign lookup_hit = rd_entry.valid && (rd_entry.tag == lookup_tag);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pred_hit    <= 1'b0;
            pred_taken  <= 1'b0;
            pred_target <= '0;
            pred_token  <= '0;
            pred_index  <= '0;
        end else if (!stall) begin
            pred_index <= lookup_idx;
            if (state == RUN && lookup_en) begin
                pred_hit    <= lookup_hit;
                pred_taken  <= lookup_hit & rd_entry.ctr[CTR_W-1];
                pred_target <= lookup_hit ? rd_entry.tgt : '0;
                pred_token  <= lookup_hit ? rd_entry.ctr : WNT;
            end else begin
                pred_hit    <= 1'b0;
                pred_taken  <= 1'b0;
                pred_target <= '0;
                pred_token  <= WNT;
            end
        end
    end

endmodule

// File: tb/tb_branch_predictor.sv
// Randomized self-checking bench for branch_predictor against an array-based reference model.
// Define BP_GSHARE_EN to check the gshare-indexed build.
module tb_branch_predictor;

    localparam int ADDR_W = 32;
    localparam int IDX_W  = 10;
    localparam int TAG_W  = 8;
    localparam int CTR_W  = 2;
    localparam int HIST_W = 8;
    localparam int DEPTH  = 1024;
    localparam int WNT    = 1;
    localparam int CMAX   = 3;

    logic              clk = 1'b0;
    logic              rst;
    logic              stall;
    logic              lookup_en;
    logic [ADDR_W-1:0] lookup_pc;
    logic              pred_hit;
    logic              pred_taken;
    logic [ADDR_W-1:0] pred_target;
    logic [CTR_W-1:0]  pred_token;
    logic [IDX_W-1:0]  pred_index;
    logic              update_en;
    logic [IDX_W-1:0]  update_index;
    logic [ADDR_W-1:0] update_pc;
    logic [CTR_W-1:0]  update_token;
    logic              update_taken;
    logic [ADDR_W-1:0] update_target;
    logic              busy;

    always #5 clk = ~clk;

    branch_predictor #(
        .ADDR_W(ADDR_W), .IDX_W(IDX_W), .TAG_W(TAG_W), .CTR_W(CTR_W), .HIST_W(HIST_W)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .stall         (stall),
        .lookup_en     (lookup_en),
        .lookup_pc     (lookup_pc),
        .pred_hit      (pred_hit),
        .pred_taken    (pred_taken),
        .pred_target   (pred_target),
        .pred_token    (pred_token),
        .pred_index    (pred_index),
        .update_en     (update_en),
        .update_index  (update_index),
        .update_pc     (update_pc),
        .update_token  (update_token),
        .update_taken  (update_taken),
        .update_target (update_target),
        .busy          (busy)
    );

    int checks_total  = 0;
    int checks_passed = 0;

    // Reference model: the table as plain arrays, counters as integers.
    bit          m_valid [DEPTH];
    int          m_tag   [DEPTH];
    int          m_ctr   [DEPTH];
    logic [31:0] m_tgt   [DEPTH];
    int          m_ghr;
    int          init_left;

    bit          e_hit, e_taken, e_index_known;
    logic [31:0] e_target;
    int          e_token, e_index;

    task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
        checks_total++;
        if (actual === expected) checks_passed++;
        else $display("[TB] FAIL %s: actual=%0h required=%0h", tag, actual, expected);
    endtask

    function automatic int model_index(input logic [31:0] pc);
        int idx;
        idx = int'((pc >> 2) % DEPTH);
`ifdef BP_GSHARE_EN
        idx = idx ^ m_ghr;
`endif
        return idx;
    endfunction

    function automatic logic [31:0] rand_pc();
        logic [31:0] pc;
        pc = ($urandom_range(0, 7) << 20) | ($urandom_range(0, 3) << 12)
           | ($urandom_range(0, 15) << 2) | $urandom_range(0, 3);
        return pc;
    endfunction

    task automatic modelReset();
        for (int i = 0; i < DEPTH; i++) m_valid[i] = 1'b0;
        m_ghr         = 0;
        init_left     = DEPTH;
        e_hit         = 1'b0;
        e_taken       = 1'b0;
        e_target      = '0;
        e_token       = 0;
        e_index       = 0;
        e_index_known = 1'b0;
    endtask

    task automatic checkAll();
        checkOutput("busy",   busy,        init_left > 0);
        checkOutput("hit",    pred_hit,    e_hit);
        checkOutput("taken",  pred_taken,  e_taken);
        checkOutput("target", pred_target, e_target);
        checkOutput("token",  pred_token,  e_token);
        if (e_index_known) checkOutput("index", pred_index, e_index);
    endtask

    task automatic applyStimulus(input bit le, input logic [31:0] pc, input bit st,
                                 input bit ue, input int uidx, input logic [31:0] upc,
                                 input int utok, input bit utaken, input logic [31:0] utgt);
        int idx;
        bit hit;
        lookup_en     = le;
        lookup_pc     = pc;
        stall         = st;
        update_en     = ue;
        update_index  = uidx[IDX_W-1:0];
        update_pc     = upc;
        update_token  = utok[CTR_W-1:0];
        update_taken  = utaken;
        update_target = utgt;
        if (init_left > 0) begin
            if (!st) begin
                e_hit = 0; e_taken = 0; e_target = 0; e_token = WNT; e_index_known = 0;
            end
            init_left--;
        end else begin
            idx = model_index(pc);
            if (ue) begin
                m_valid[uidx] = 1'b1;
                m_tag[uidx]   = int'((upc >> 12) & 255);
                m_ctr[uidx]   = utaken ? ((utok + 1 > CMAX) ? CMAX : utok + 1)
                                       : ((utok - 1 < 0) ? 0 : utok - 1);
                m_tgt[uidx]   = utgt;
`ifdef BP_GSHARE_EN
                m_ghr = ((m_ghr << 1) | int'(utaken)) & 255;
`endif
            end
            if (!st) begin
                if (le) begin
                    hit           = m_valid[idx] && (m_tag[idx] == int'((pc >> 12) & 255));
                    e_hit         = hit;
                    e_taken       = hit && (m_ctr[idx] >= 2);
                    e_target      = hit ? m_tgt[idx] : 32'h0;
                    e_token       = hit ? m_ctr[idx] : WNT;
                    e_index       = idx;
                    e_index_known = 1'b1;
                end else begin
                    e_hit = 0; e_taken = 0; e_target = 0; e_token = WNT; e_index_known = 0;
                end
            end
        end
        @(posedge clk);
        #1;
        checkAll();
    endtask

    task automatic randomCycle(input int stall_pct);
        logic [31:0] upc;
        upc = rand_pc();
        applyStimulus($urandom_range(0, 3) != 0, rand_pc(), $urandom_range(0, 99) < stall_pct,
                      $urandom_range(0, 1) == 1, int'((upc >> 2) & 15), upc,
                      $urandom_range(0, 3), $urandom_range(0, 1) == 1, $urandom());
    endtask

    task automatic doReset();
        rst = 1'b1;
        #1;
        modelReset();
        checkOutput("rst_busy",   busy,        1);
        checkOutput("rst_hit",    pred_hit,    0);
        checkOutput("rst_taken",  pred_taken,  0);
        checkOutput("rst_target", pred_target, 0);
        checkOutput("rst_token",  pred_token,  0);
        checkOutput("rst_index",  pred_index,  0);
        @(posedge clk);
        @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    initial begin
        stall = 0; lookup_en = 0; lookup_pc = 0; update_en = 0; update_index = 0;
        update_pc = 0; update_token = 0; update_taken = 0; update_target = 0;
        doReset();

        // Sweep: lookups and updates during INIT must be ignored.
        repeat (DEPTH) randomCycle(0);

        applyStimulus(0, 32'h0, 0, 1, 5, 32'h14, 1, 1, 32'h100);
        applyStimulus(1, 32'h14, 0, 0, 0, 32'h0, 0, 0, 32'h0);
        for (int i = 0; i < 8; i++)
            applyStimulus(1, 32'h14, 0, 1, 5, 32'h14, m_ctr[5], i < 4, 32'h100);
        applyStimulus(1, 32'h1014, 0, 0, 0, 32'h0, 0, 0, 32'h0);

        applyStimulus(0, 32'h0, 0, 1, 5, 32'h14, 2, 1, 32'h140);
        applyStimulus(1, 32'h14, 0, 0, 0, 32'h0, 0, 0, 32'h0);
        for (int i = 0; i < 3; i++)
            applyStimulus(1, rand_pc(), 1, 0, 0, 32'h0, 0, 0, 32'h0);
        applyStimulus(1, 32'h1c, 0, 1, 7, 32'h1c, 2, 1, 32'h200);

        repeat (2000) randomCycle(12);

        doReset();
        repeat (DEPTH) randomCycle(10);
        applyStimulus(1, 32'h14, 0, 1, 5, 32'h14, 1, 1, 32'h300);
        repeat (300) randomCycle(12);

        $display("[TB] %0d/%0d checks passed", checks_passed, checks_total);
        $finish;
    end

endmodule
